// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 encryptor: top-level states and
// the read/wait/write micro-steps used inside KSA, LEN and PRGA.
package arc4_pkg;

   localparam int SBOX_SIZE = 256;
   localparam int KEY_W     = 24;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      KSA,
      LEN,
      PRGA,
      DONE
   } arc4_state_t;

   typedef enum logic [3:0] {
      RD_I,
      WT_I,
      GET_I,
      WT_J,
      WR_I,
      WR_J,
      RD_P,
      WT_P,
      WR_CT
   } arc4_step_t;

endpackage

// File: rtl/arc4_keybyte.sv
// Selects key byte idx of a big-endian packed key (byte 0 is the top byte).
module arc4_keybyte #(
   parameter int KEY_BYTES = 3,
   parameter int IDX_W     = 2
) (
   input  logic [KEY_BYTES*8-1:0] key,
   input  logic [IDX_W-1:0]       idx,
   output logic [7:0]             kbyte
);

   always_comb begin
      kbyte = key[(KEY_BYTES*8-1) - 8*int'(idx) -: 8];
   end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: fills the external S-box, runs KSA, then XORs the PRGA
// keystream over a length-prefixed plaintext into a length-prefixed ciphertext.
//
// state | meaning
// IDLE  | rdy=1, waiting for en
// INIT  | S[i]=i, one write per cycle, exits when i wraps
// KSA   | key schedule, 6-step loop per i
// LEN   | read pt[0], write ct[0]=len
// PRGA  | keystream and ct[k] write, 9-step loop per byte
// DONE  | last ct write on the bus, rdy returns next cycle
module arc4_encrypt
   import arc4_pkg::*;
#(
   parameter int KEY_BYTES = 3,
   parameter int MEM_LAT   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             rdy,
   input  logic [KEY_W-1:0] key,
   output logic [7:0]       s_addr,
   input  logic [7:0]       s_rddata,
   output logic [7:0]       s_wrdata,
   output logic             s_wren,
   output logic [7:0]       pt_addr,
   input  logic [7:0]       pt_rddata,
   output logic [7:0]       ct_addr,
   output logic [7:0]       ct_wrdata,
   output logic             ct_wren
);

   localparam int         IDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   arc4_state_t      state;
   arc4_step_t       step;
   logic [7:0]       i, j, si, sj, len, pt_byte, kbyte, j_nxt;
   logic [8:0]       k;
   logic [KEY_W-1:0] key_r;
   logic [IDX_W-1:0] kidx;
   logic [3:0]       wait_cnt;

   arc4_keybyte #(
      .KEY_BYTES (KEY_BYTES),
      .IDX_W     (IDX_W)
   ) u_keybyte (
      .key   (key_r),
      .idx   (kidx),
      .kbyte (kbyte)
   );

   // KSA adds the key byte into j, PRGA does not
   always_comb begin
      j_nxt = j + s_rddata + ((state == KSA) ? kbyte : 8'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         step      <= RD_I;
         rdy       <= 1'b1;
         s_addr    <= '0;
         s_wrdata  <= '0;
         s_wren    <= 1'b0;
         pt_addr   <= '0;
         ct_addr   <= '0;
         ct_wrdata <= '0;
         ct_wren   <= 1'b0;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         si        <= '0;
         sj        <= '0;
         len       <= '0;
         pt_byte   <= '0;
         key_r     <= '0;
         kidx      <= '0;
         wait_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en && rdy) begin
                  key_r    <= key;
                  rdy      <= 1'b0;
                  i        <= '0;
                  s_addr   <= '0;
                  s_wrdata <= '0;
                  s_wren   <= 1'b1;
                  state    <= INIT;
               end
            end
            INIT: begin
               i <= i + 8'd1;
               if (i == 8'(SBOX_SIZE - 1)) begin
                  s_wren <= 1'b0;
                  j      <= '0;
                  kidx   <= '0;
                  step   <= RD_I;
                  state  <= KSA;
               end else begin
                  s_addr   <= i + 8'd1;
                  s_wrdata <= i + 8'd1;
               end
            end
            KSA, PRGA: begin
               case (step)
                  RD_I: begin
                     s_wren   <= 1'b0;
                     ct_wren  <= 1'b0;
                     wait_cnt <= LAT_LOAD;
                     step     <= WT_I;
                     if (state == PRGA) begin
                        i       <= i + 8'd1;
                        s_addr  <= i + 8'd1;
                        pt_addr <= k[7:0];
                     end else begin
                        s_addr  <= i;
                     end
                  end
                  WT_I: begin
                     if (wait_cnt == 4'd0) step <= GET_I;
                     else wait_cnt <= wait_cnt - 4'd1;
                  end
                  GET_I: begin
                     si       <= s_rddata;
                     pt_byte  <= pt_rddata;
                     j        <= j_nxt;
                     s_addr   <= j_nxt;
                     wait_cnt <= LAT_LOAD;
                     step     <= WT_J;
                  end
                  WT_J: begin
                     if (wait_cnt == 4'd0) step <= WR_I;
                     else wait_cnt <= wait_cnt - 4'd1;
                  end
                  WR_I: begin
                     sj       <= s_rddata;
                     s_addr   <= i;
                     s_wrdata <= s_rddata;
                     s_wren   <= 1'b1;
                     step     <= WR_J;
                  end
                  WR_J: begin
                     s_addr   <= j;
                     s_wrdata <= si;
                     s_wren   <= 1'b1;
                     if (state == PRGA) begin
                        step <= RD_P;
                     end else begin
                        i    <= i + 8'd1;
                        kidx <= (kidx == IDX_W'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
                        step <= RD_I;
                        if (i == 8'(SBOX_SIZE - 1)) state <= LEN;
                     end
                  end
                  RD_P: begin
                     s_wren   <= 1'b0;
                     s_addr   <= si + sj;
                     wait_cnt <= LAT_LOAD;
                     step     <= WT_P;
                  end
                  WT_P: begin
                     if (wait_cnt == 4'd0) step <= WR_CT;
                     else wait_cnt <= wait_cnt - 4'd1;
                  end
                  WR_CT: begin
                     ct_addr   <= k[7:0];
                     ct_wrdata <= s_rddata ^ pt_byte;
                     ct_wren   <= 1'b1;
                     step      <= RD_I;
                     if (k == {1'b0, len}) state <= DONE;
                     else k <= k + 9'd1;
                  end
                  default: step <= RD_I;
               endcase
            end
            LEN: begin
               case (step)
                  RD_I: begin
                     s_wren   <= 1'b0;
                     pt_addr  <= '0;
                     wait_cnt <= LAT_LOAD;
                     step     <= WT_I;
                  end
                  WT_I: begin
                     if (wait_cnt == 4'd0) step <= GET_I;
                     else wait_cnt <= wait_cnt - 4'd1;
                  end
                  default: begin
                     len       <= pt_rddata;
                     ct_addr   <= '0;
                     ct_wrdata <= pt_rddata;
                     ct_wren   <= 1'b1;
                     i         <= '0;
                     j         <= '0;
                     k         <= 9'd1;
                     step      <= RD_I;
                     state     <= (pt_rddata == 8'd0) ? DONE : PRGA;
                  end
               endcase
            end
            DONE: begin
               s_wren  <= 1'b0;
               ct_wren <= 1'b0;
               rdy     <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: RAM models, directed vectors, and a ct-write
// scoreboard fed by the stimulus and drained by an independent monitor.
module tb_arc4_encrypt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [23:0] key = '0;
   logic        rdy, s_wren, ct_wren;
   logic [7:0]  s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata;
   logic [7:0]  ct_addr, ct_wrdata;

   logic [7:0]  s_mem [256];
   logic [7:0]  pt_mem [256];
   logic [7:0]  ct_mem [256];
   logic [7:0]  pt_buf [256];
   logic [7:0]  exp_buf [256];
   logic [15:0] exp_q [$];
   logic [15:0] mon_e;

   int total = 0;
   int bad = 0;
   int ct_writes = 0;
   int s_writes = 0;
   int found;
   bit match;

   localparam logic [23:0] KEY_V1 = 24'h4B6579;
   logic [7:0] v1_pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
   logic [7:0] v1_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

   always #5 clk = ~clk;

   arc4_encrypt dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rdy       (rdy),
      .key       (key),
      .s_addr    (s_addr),
      .s_rddata  (s_rddata),
      .s_wrdata  (s_wrdata),
      .s_wren    (s_wren),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .ct_addr   (ct_addr),
      .ct_wrdata (ct_wrdata),
      .ct_wren   (ct_wren)
   );

   always @(posedge clk) begin
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      s_rddata  <= s_mem[s_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
   end

   // monitor: every ct write is checked against the head of the queue
   always @(negedge clk) begin
      if (rst_n) begin
         if (s_wren) s_writes++;
         if (ct_wren) begin
            ct_writes++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL ct_unexpected: got addr=%0d data=%02h, required no write", ct_addr, ct_wrdata);
            end else begin
               mon_e = exp_q.pop_front();
               if ({ct_addr, ct_wrdata} !== mon_e) begin
                  bad++;
                  $display("FAIL ct_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                           ct_addr, ct_wrdata, mon_e[15:8], mon_e[7:0]);
               end
            end
         end
      end
   end

   function automatic void model(input logic [23:0] k, input int n);
      logic [7:0] s [256];
      logic [7:0] i, j, t, kb, idx;
      for (int x = 0; x < 256; x++) s[x] = 8'(x);
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         kb = 8'(k >> (16 - 8 * (x % 3)));
         j = j + s[x] + kb;
         t = s[x]; s[x] = s[j]; s[j] = t;
      end
      i = 8'd0;
      j = 8'd0;
      for (int x = 1; x <= n; x++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i]; s[i] = s[j]; s[j] = t;
         idx = s[i] + s[j];
         exp_buf[x] = s[idx] ^ pt_buf[x];
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic set_v1_pt();
      for (int x = 0; x < 9; x++) pt_buf[x + 1] = v1_pt[x];
   endtask

   task automatic start(input logic [23:0] k);
      @(negedge clk);
      en  = 1'b1;
      key = k;
      @(posedge clk);
      #1;
      en  = 1'b0;
      key = 24'($urandom);
      check("rdy_drop", {31'd0, rdy}, 32'd0);
   endtask

   task automatic run(input logic [23:0] k, input int n, input bit disturb, input bit use_v1);
      int cycles;
      pt_mem[0] = 8'(n);
      for (int x = 1; x <= n; x++) pt_mem[x] = pt_buf[x];
      exp_q.push_back({8'd0, 8'(n)});
      if (use_v1) begin
         for (int x = 0; x < 9; x++) exp_q.push_back({8'(x + 1), v1_ct[x]});
      end else begin
         model(k, n);
         for (int x = 1; x <= n; x++) exp_q.push_back({8'(x), exp_buf[x]});
      end
      ct_writes = 0;
      s_writes  = 0;
      start(k);
      cycles = 0;
      while (!rdy && cycles < 6000) begin
         @(posedge clk);
         #1;
         cycles++;
         en = disturb && (cycles == 100);
      end
      en = 1'b0;
      check("rdy_return", {31'd0, rdy}, 32'd1);
      check("cycle_bound", {31'd0, cycles <= 1800 + 9 * n}, 32'd1);
      check("queue_drained", exp_q.size(), 32'd0);
      check("ct_write_count", ct_writes, n + 1);
      check("s_write_count", s_writes, 768 + 2 * n);
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

   initial begin
      for (int x = 0; x < 256; x++) begin
         s_mem[x]  = 8'h00;
         pt_mem[x] = 8'h00;
         ct_mem[x] = 8'h00;
         pt_buf[x] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", {31'd0, rdy}, 32'd1);
      check("rst_s_wren", {31'd0, s_wren}, 32'd0);
      check("rst_ct_wren", {31'd0, ct_wren}, 32'd0);
      check("rst_addrs", {8'd0, s_addr, pt_addr, ct_addr}, 32'd0);
      check("rst_wrdata", {16'd0, s_wrdata, ct_wrdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_rdy", {31'd0, rdy}, 32'd1);

      // vector 1: "Key" / "Plaintext"
      set_v1_pt();
      run(KEY_V1, 9, 1'b0, 1'b1);

      // zero length
      run(24'hABCDEF, 0, 1'b0, 1'b0);

      // 255 zero bytes, zero key
      for (int x = 1; x < 256; x++) pt_buf[x] = 8'h00;
      run(24'h000000, 255, 1'b0, 1'b0);

      // en pulsed mid-run is ignored
      set_v1_pt();
      run(KEY_V1, 9, 1'b1, 1'b1);

      // reset mid-KSA, then a clean vector 1
      pt_mem[0] = 8'd9;
      for (int x = 1; x <= 9; x++) pt_mem[x] = pt_buf[x];
      ct_writes = 0;
      start(KEY_V1);
      repeat (400) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_rdy", {31'd0, rdy}, 32'd1);
      check("midrst_s_wren", {31'd0, s_wren}, 32'd0);
      check("midrst_ct_wren", {31'd0, ct_wren}, 32'd0);
      check("midrst_no_ct", ct_writes, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run(KEY_V1, 9, 1'b0, 1'b1);

      // back-to-back: vector 1 then key 1 on the same plaintext
      run(KEY_V1, 9, 1'b0, 1'b1);
      run(24'h000001, 9, 1'b0, 1'b0);

      // bounded known-plaintext key search over what the DUT left in ct_mem
      found = -1;
      for (int cand = 0; cand < 16; cand++) begin
         model(24'(cand), 9);
         match = 1'b1;
         for (int x = 1; x <= 9; x++) if (exp_buf[x] !== ct_mem[x]) match = 1'b0;
         if (match && found < 0) found = cand;
      end
      check("crack_key", found, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
